// File: rtl/ntt_bfu_array.sv
// Pipelined array of Cooley-Tukey butterflies for the ML-KEM forward NTT (q = 3329).
// Three register stages under one global stall: operands, reduced product, corrected sum/diff.
module ntt_bfu_array #(
  parameter int HALF_NUM_BFU = 16,
  localparam int NUM_BFU = HALF_NUM_BFU * 2,
  parameter int Q = 3329
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [16*NUM_BFU-1:0]   i_a,
  input  logic [16*NUM_BFU-1:0]   i_b,
  input  logic [16*NUM_BFU-1:0]   i_w,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [16*NUM_BFU-1:0]   o_a,
  output logic [16*NUM_BFU-1:0]   o_b,
  output logic                    o_busy
);

  localparam logic [12:0] QW = 13'(Q);

  // Out-of-range operands saturate to 4095; results are then undefined but stay bounded.
  function automatic logic [11:0] f_sat(input logic [15:0] x);
    return x[11:0] | {12{|x[15:12]}};
  endfunction

  logic r_v1, r_v2, r_v3;
  logic w_adv;

  assign w_adv   = !r_v3 || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_v3;
  assign o_busy  = r_v1 | r_v2 | r_v3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BFU; gi++) begin : g_bfu
      logic [11:0] r_a1, r_b1, r_w1, r_a2, r_r2, r_oa, r_ob;
      logic [23:0] w_p;
      logic [12:0] w_qe, w_qq, w_t, w_sum, w_diff;
      logic [11:0] w_r, w_sumc, w_diffc;

      // Barrett: quotient estimate is at most one short, so r < 2Q before the final subtract.
      assign w_p    = {12'd0, r_w1} * {12'd0, r_b1};
      assign w_qe   = 13'(({13'd0, w_p} * 37'd5039) >> 24);
      assign w_qq   = w_qe * QW;
      assign w_t    = w_p[12:0] - w_qq;
      assign w_r    = (w_t >= QW) ? 12'(w_t - QW) : w_t[11:0];

      assign w_sum   = {1'b0, r_a2} + {1'b0, r_r2};
      assign w_sumc  = (w_sum >= QW) ? 12'(w_sum - QW) : w_sum[11:0];
      assign w_diff  = {1'b0, r_a2} - {1'b0, r_r2};
      assign w_diffc = (r_a2 < r_r2) ? 12'(w_diff + QW) : w_diff[11:0];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_a1 <= '0;
          r_b1 <= '0;
          r_w1 <= '0;
          r_a2 <= '0;
          r_r2 <= '0;
          r_oa <= '0;
          r_ob <= '0;
        end else if (w_adv) begin
          r_a1 <= f_sat(i_a[16*gi +: 16]);
          r_b1 <= f_sat(i_b[16*gi +: 16]);
          r_w1 <= f_sat(i_w[16*gi +: 16]);
          r_a2 <= r_a1;
          r_r2 <= w_r;
          r_oa <= w_sumc;
          r_ob <= w_diffc;
        end
      end

      assign o_a[16*gi +: 16] = {4'd0, r_oa};
      assign o_b[16*gi +: 16] = {4'd0, r_ob};
    end
  endgenerate

endmodule

// File: tb/tb_ntt_bfu_array.sv
// Directed and random checks of ntt_bfu_array against a per-lane (a +/- w*b) mod q model.
module tb_ntt_bfu_array;
  localparam int N = 32;
  localparam int Q = 3329;
  localparam int W = 16 * N;

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, o_ready, i_ready, o_valid, o_busy;
  logic [W-1:0] i_a, i_b, i_w, o_a, o_b;

  typedef struct {
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    bit           dc;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, out_cnt = 0, in_cnt = 0;

  always #5 i_clk = ~i_clk;

  ntt_bfu_array #(.HALF_NUM_BFU(16), .Q(Q)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_w(i_w), .o_valid(o_valid), .i_ready(i_ready),
    .o_a(o_a), .o_b(o_b), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] w, output logic [W-1:0] ea,
                                output logic [W-1:0] eb, output bit dc);
    longint av, bv, wv, r;
    dc = 0;
    ea = '0;
    eb = '0;
    for (int k = 0; k < N; k++) begin
      av = longint'(a[16*k +: 16]);
      bv = longint'(b[16*k +: 16]);
      wv = longint'(w[16*k +: 16]);
      if (av >= Q || bv >= Q || wv >= Q) dc = 1;
      r = (wv * bv) % Q;
      ea[16*k +: 16] = 16'((av + r) % Q);
      eb[16*k +: 16] = 16'((av - r + Q) % Q);
    end
  endfunction

  always @(negedge i_clk) begin : mon
    exp_t e;
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        out_cnt++;
        $display("out %0d lane0 a=%0d b=%0d", out_cnt, o_a[15:0], o_b[15:0]);
        if (sb.size() == 0) chk("extra_out", W'(1), W'(0));
        else begin
          e = sb.pop_front();
          if (!e.dc) begin
            chk("sb_a", o_a, e.ea);
            chk("sb_b", o_b, e.eb);
          end
        end
      end
      if (i_valid && o_ready) begin
        model(i_a, i_b, i_w, e.ea, e.eb, e.dc);
        sb.push_back(e);
        in_cnt++;
      end
    end
  end

  function automatic logic [15:0] rnd();
    return ($urandom_range(0, 7) == 0) ? 16'(Q - 1) : 16'($urandom_range(0, Q - 1));
  endfunction

  task automatic rand_ops();
    for (int k = 0; k < N; k++) begin
      i_a[16*k +: 16] = rnd();
      i_b[16*k +: 16] = rnd();
      i_w[16*k +: 16] = rnd();
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge i_clk);
      n++;
    end
    @(negedge i_clk);
    chk(tag, W'(sb.size()), W'(0));
    @(posedge i_clk); #1;
  endtask

  logic [W-1:0] ea, eb, held_a, held_b;
  int           base, cyc;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0; i_w = '0;
    #12;
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_busy", W'(o_busy), W'(0));
    chk("rst_oa", o_a, '0);
    chk("rst_ob", o_b, '0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("rst_ready", W'(o_ready), W'(1));

    // Directed beat with hand-computed lanes; other lanes zero.
    ea = '0; eb = '0;
    i_a[16*0 +: 16] = 16'd1;    i_b[16*0 +: 16] = 16'd1;    i_w[16*0 +: 16] = 16'd1;
    ea[16*0 +: 16] = 16'd2;     eb[16*0 +: 16] = 16'd0;
    i_a[16*1 +: 16] = 16'd0;    i_b[16*1 +: 16] = 16'd1;    i_w[16*1 +: 16] = 16'd1;
    ea[16*1 +: 16] = 16'd1;     eb[16*1 +: 16] = 16'd3328;
    i_a[16*2 +: 16] = 16'd3328; i_b[16*2 +: 16] = 16'd3328; i_w[16*2 +: 16] = 16'd3328;
    ea[16*2 +: 16] = 16'd0;     eb[16*2 +: 16] = 16'd3327;
    i_a[16*3 +: 16] = 16'd20;   i_b[16*3 +: 16] = 16'd3328; i_w[16*3 +: 16] = 16'd17;
    ea[16*3 +: 16] = 16'd3;     eb[16*3 +: 16] = 16'd37;
    i_a[16*4 +: 16] = 16'd1234; i_b[16*4 +: 16] = 16'd999;  i_w[16*4 +: 16] = 16'd0;
    ea[16*4 +: 16] = 16'd1234;  eb[16*4 +: 16] = 16'd1234;
    i_a[16*31 +: 16] = 16'd0;   i_b[16*31 +: 16] = 16'd3328; i_w[16*31 +: 16] = 16'd3328;
    ea[16*31 +: 16] = 16'd1;    eb[16*31 +: 16] = 16'd3328;
    i_valid = 1'b1;
    @(negedge i_clk);
    chk("basic_ready", W'(o_ready), W'(1));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk); chk("lat_c1", W'(o_valid), W'(0));
    @(negedge i_clk); chk("lat_c2", W'(o_valid), W'(0));
    @(negedge i_clk); chk("lat_c3", W'(o_valid), W'(1));
    chk("basic_oa", o_a, ea);
    chk("basic_ob", o_b, eb);
    @(posedge i_clk); #1;
    drain("basic_drain");

    // Streaming: 64 back-to-back beats must come out on 64 consecutive cycles.
    base = out_cnt;
    for (int i = 0; i < 64; i++) begin
      rand_ops();
      i_valid = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk); #1;
    chk("stream_cnt", W'(out_cnt - base), W'(64));
    drain("stream_drain");

    // Backpressure: stall with beats in flight and a beat on offer.
    base = out_cnt;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      i_valid = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    held_a = o_a;
    held_b = o_b;
    rand_ops();
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("bp_ready", W'(o_ready), W'(0));
      chk("bp_valid", W'(o_valid), W'(1));
      chk("bp_hold_a", o_a, held_a);
      chk("bp_hold_b", o_b, held_b);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    drain("bp_drain");
    chk("bp_cnt", W'(out_cnt - base), W'(4));

    // Out-of-range operands: values undefined, but the beat must still emerge.
    base = out_cnt;
    i_a = '1; i_b = '1; i_w = '1;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    drain("oor_drain");
    chk("oor_cnt", W'(out_cnt - base), W'(1));

    // Random valid/ready traffic.
    base = in_cnt;
    cyc = 0;
    while (in_cnt < base + 10000 && cyc < 60000) begin
      rand_ops();
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      @(posedge i_clk); #1;
      cyc++;
    end
    chk("rand_in_cnt", W'(in_cnt - base >= 10000), W'(1));
    drain("rand_drain");

    // Reset with beats in flight.
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      i_valid = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk("busy_inflight", W'(o_busy), W'(1));
    #2;
    i_rst = 1'b1;
    #1;
    chk("mrst_valid", W'(o_valid), W'(0));
    chk("mrst_busy", W'(o_busy), W'(0));
    chk("mrst_oa", o_a, '0);
    chk("mrst_ob", o_b, '0);
    sb.delete();
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("mrst_ready", W'(o_ready), W'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("mrst_no_ghost", W'(o_valid), W'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
